// File: rtl/spike_rate_pkg.sv
// Shared constants and helpers for the spike-rate readout path.
// Channel map: four pre-synaptic spikes plus the post-synaptic neuron.
package spike_rate_pkg;
   localparam int N_CH_DEF     = 5;
   localparam int CNT_W_DEF    = 8;
   localparam int WIN_LOG2_DEF = 8;
   localparam int CNT_W_MAX    = 32;

   localparam int CH_PRE1 = 0;
   localparam int CH_PRE2 = 1;
   localparam int CH_PRE3 = 2;
   localparam int CH_PRE4 = 3;
   localparam int CH_POST = 4;

   typedef struct packed {
      logic                 ovf;
      logic [CNT_W_MAX-1:0] val;
   } sat_res_t;

   // The count sticks at cmax; ovf flags an increment that was dropped.
   function automatic sat_res_t sat_inc(input logic [CNT_W_MAX-1:0] cnt,
                                        input logic                 inc,
                                        input logic [CNT_W_MAX-1:0] cmax);
      sat_res_t r;
      r.ovf = inc && (cnt == cmax);
      r.val = (inc && !r.ovf) ? cnt + CNT_W_MAX'(1) : cnt;
      return r;
   endfunction
endpackage

// File: rtl/spike_rate_counter.sv
// Per-channel saturating spike counter with a sticky saturation bit.
// The outputs are the value that would be published if this cycle ends a window.
module spike_rate_counter
   import spike_rate_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             inc,
   input  logic             last,
   output logic [CNT_W-1:0] pub_cnt,
   output logic             pub_sat
);
   localparam logic [CNT_W_MAX-1:0] CMAX = CNT_W_MAX'({CNT_W{1'b1}});

   logic [CNT_W-1:0] cnt;
   logic             sat;
   sat_res_t         res;

   always_comb res = sat_inc(CNT_W_MAX'(cnt), inc, CMAX);

   assign pub_cnt = res.val[CNT_W-1:0];
   assign pub_sat = sat | res.ovf;

   if (CNT_W < CNT_W_MAX) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^res.val[CNT_W_MAX-1:CNT_W];
   end

   // The last window cycle hands its sum to the top and restarts from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         sat <= 1'b0;
      end else if (clr || (en && last)) begin
         cnt <= '0;
         sat <= 1'b0;
      end else if (en) begin
         cnt <= pub_cnt;
         sat <= pub_sat;
      end
   end
endmodule

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spikes per channel over 2^WIN_LOG2 enabled cycles
// and publishes saturated counts at each window boundary.
module spike_rate_decoder
   import spike_rate_pkg::*;
#(
   parameter int N_CH     = N_CH_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  clr,
   input  logic [N_CH-1:0]       spike_in,
   input  logic [2:0]            sel,
   output logic [N_CH*CNT_W-1:0] rate_out,
   output logic [CNT_W-1:0]      rate_sel,
   output logic                  rate_valid,
   output logic [N_CH-1:0]       sat_flags
);
   localparam logic [WIN_LOG2-1:0] WPOS_LAST = '1;

   logic [WIN_LOG2-1:0]   wpos;
   logic                  last;
   logic [N_CH*CNT_W-1:0] pub_cnt;
   logic [N_CH-1:0]       pub_sat;

   assign last = (wpos == WPOS_LAST);

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      spike_rate_counter #(
         .CNT_W(CNT_W)
      ) u_cnt (
         .clk    (clk),
         .rst    (rst),
         .en     (en),
         .clr    (clr),
         .inc    (spike_in[k]),
         .last   (last),
         .pub_cnt(pub_cnt[k*CNT_W +: CNT_W]),
         .pub_sat(pub_sat[k])
      );
   end

   // Window position and publish register; clr restarts silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wpos       <= '0;
         rate_out   <= '0;
         sat_flags  <= '0;
         rate_valid <= 1'b0;
      end else begin
         rate_valid <= 1'b0;
         if (clr) begin
            wpos <= '0;
         end else if (en) begin
            wpos <= wpos + WIN_LOG2'(1);
            if (last) begin
               rate_out   <= pub_cnt;
               sat_flags  <= pub_sat;
               rate_valid <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      rate_sel = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (sel == 3'(k)) rate_sel = rate_out[k*CNT_W +: CNT_W];
      end
   end
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder with default parameters (5 ch, 8-bit, 256-cycle window).
module tb_spike_rate_decoder;
   import spike_rate_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        clr;
   logic [4:0]  spike_in;
   logic [2:0]  sel;
   logic [39:0] rate_out;
   logic [7:0]  rate_sel;
   logic        rate_valid;
   logic [4:0]  sat_flags;

   int total = 0;
   int bad   = 0;
   int cyc;
   int npulse;
   int first_pulse;

   spike_rate_decoder dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .clr       (clr),
      .spike_in  (spike_in),
      .sel       (sel),
      .rate_out  (rate_out),
      .rate_sel  (rate_sel),
      .rate_valid(rate_valid),
      .sat_flags (sat_flags)
   );

   always #5 clk = ~clk;

   function automatic logic [39:0] pk(input int c0, input int c1, input int c2,
                                      input int c3, input int c4);
      return {8'(c4), 8'(c3), 8'(c2), 8'(c1), 8'(c0)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_track();
      cyc         = 0;
      npulse      = 0;
      first_pulse = -1;
   endtask

   task automatic cycle(input logic [4:0] sp, input logic e, input logic c);
      spike_in = sp;
      en       = e;
      clr      = c;
      tick();
      cyc++;
      if (rate_valid) begin
         npulse++;
         if (first_pulse < 0) first_pulse = cyc;
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; clr = 1'b0; spike_in = '0; sel = 3'd0;
      tick();
      tick();
      chk("reset_rate_out", rate_out, 40'd0);
      chk("reset_sat_flags", sat_flags, 5'd0);
      chk("reset_valid", rate_valid, 1'b0);
      rst = 1'b0;

      // Empty window: one publish at cycle 256, all zero
      reset_track();
      for (int i = 0; i < 256; i++) cycle(5'b00000, 1'b1, 1'b0);
      chk("empty_npulse", npulse, 1);
      chk("empty_first", first_pulse, 256);
      chk("empty_rate_out", rate_out, 40'd0);
      chk("empty_sat", sat_flags, 5'd0);

      // ch0 every cycle, ch4 every 4th cycle
      reset_track();
      for (int i = 0; i < 256; i++) cycle({(i % 4 == 0), 3'b000, 1'b1}, 1'b1, 1'b0);
      chk("rate_npulse", npulse, 1);
      chk("rate_first", first_pulse, 256);
      chk("rate_valid_now", rate_valid, 1'b1);
      chk("rate_out_sat", rate_out, pk(255, 0, 0, 0, 64));
      chk("sat_flags_ch0", sat_flags, 5'b00001);
      sel = 3'(CH_POST);
      #1 chk("rate_sel_post", rate_sel, 8'd64);
      sel = 3'(CH_PRE1);
      #1 chk("rate_sel_pre1", rate_sel, 8'd255);
      sel = 3'd5;
      #1 chk("rate_sel_5", rate_sel, 8'd0);
      sel = 3'd7;
      #1 chk("rate_sel_7", rate_sel, 8'd0);
      sel = 3'd0;

      // Single ch2 spike in last window cycle; rate_out held mid-window
      reset_track();
      for (int i = 0; i < 256; i++) begin
         cycle((i == 255) ? 5'b00100 : 5'b00000, 1'b1, 1'b0);
         if (i == 100) chk("hold_mid_window", rate_out, pk(255, 0, 0, 0, 64));
      end
      chk("last_spike_rate", rate_out, pk(0, 0, 1, 0, 0));
      chk("last_spike_sat", sat_flags, 5'd0);
      chk("last_spike_first", first_pulse, 256);
      reset_track();
      for (int i = 0; i < 256; i++) cycle(5'b00000, 1'b1, 1'b0);
      chk("next_window_zero", rate_out, 40'd0);
      chk("next_window_first", first_pulse, 256);

      // en low for 100 cycles mid-window, spikes toggling during the gap
      reset_track();
      begin
         int ei;
         ei = 0;
         for (int i = 0; i < 356; i++) begin
            if (i >= 50 && i < 150) begin
               cycle((i % 2 != 0) ? 5'b11111 : 5'b01010, 1'b0, 1'b0);
               if (i == 149) begin
                  chk("en_low_hold", rate_out, 40'd0);
                  chk("en_low_no_valid", npulse, 0);
               end
            end else begin
               cycle((ei < 10) ? 5'b00010 : 5'b00000, 1'b1, 1'b0);
               ei++;
            end
         end
      end
      chk("en_low_first", first_pulse, 356);
      chk("en_low_npulse", npulse, 1);
      chk("en_low_rate", rate_out, pk(0, 10, 0, 0, 0));

      // clr at wpos=200 with cnt[1]=50
      reset_track();
      for (int i = 0; i < 200; i++) cycle((i < 50) ? 5'b00010 : 5'b00000, 1'b1, 1'b0);
      cycle(5'b00010, 1'b1, 1'b1);
      chk("clr_no_valid", rate_valid, 1'b0);
      chk("clr_npulse", npulse, 0);
      chk("clr_hold", rate_out, pk(0, 10, 0, 0, 0));
      reset_track();
      for (int i = 0; i < 256; i++) cycle((i < 3) ? 5'b00001 : 5'b00000, 1'b1, 1'b0);
      chk("after_clr_first", first_pulse, 256);
      chk("after_clr_npulse", npulse, 1);
      chk("after_clr_rate", rate_out, pk(3, 0, 0, 0, 0));

      // Asynchronous reset mid-window with nonzero counts
      for (int i = 0; i < 100; i++) cycle(5'b11111, 1'b1, 1'b0);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_rate", rate_out, 40'd0);
      chk("async_rst_sat", sat_flags, 5'd0);
      chk("async_rst_valid", rate_valid, 1'b0);
      chk("async_rst_sel", rate_sel, 8'd0);
      tick();
      rst = 1'b0;
      reset_track();
      for (int i = 0; i < 256; i++) cycle((i % 2 == 0) ? 5'b00100 : 5'b00000, 1'b1, 1'b0);
      chk("post_rst_first", first_pulse, 256);
      chk("post_rst_npulse", npulse, 1);
      chk("post_rst_rate", rate_out, pk(0, 0, 128, 0, 0));
      chk("post_rst_sat", sat_flags, 5'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Rate decoder for the LIF spike outputs: the inverse of the neuron's current-to-spike encoding. Counts spikes per channel over a fixed window of clock cycles and publishes one saturated count per channel at each window boundary, recovering a rate estimate of the input current. It sits beside the STDP learning block on the pre- and post-synaptic spike vector and drives the debug and readout path to the output pins.

## Interface
Parameters:
- N_CH, 5: spike channels (4 pre-synaptic + 1 post-synaptic).
- CNT_W, 8: count width per channel.
- WIN_LOG2, 8: window length = 2^WIN_LOG2 enabled cycles.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  count enable; low freezes window position and counts, spikes ignored.
- clr  in  1  synchronous restart: window position and counts to 0, nothing published.
- spike_in  in  N_CH  one spike flag per channel, sampled each cycle.
- sel  in  3  channel select for rate_sel.
- rate_out  out  N_CH*CNT_W  last published counts; channel k at [k*CNT_W +: CNT_W].
- rate_sel  out  CNT_W  rate_out slice for channel sel, combinational; 0 if sel >= N_CH.
- rate_valid  out  1  one-cycle pulse: rate_out just updated.
- sat_flags  out  N_CH  per channel: published count saturated in the last window.

## Operation
- Window counter wpos, WIN_LOG2 bits, advances by 1 on each cycle with en=1. It wraps from 2^WIN_LOG2-1 to 0.
- Per channel, count cnt[k] holds CNT_W bits plus a sticky sat[k] bit.
- Enabled cycle with wpos < max: cnt[k] <= min(cnt[k] + spike_in[k], 2^CNT_W-1). sat[k] is set if the add would overflow.
- Enabled cycle with wpos == max (last cycle) does all of the following:
  - rate_out[k] <= saturated cnt[k] + spike_in[k]. The last-cycle spike is counted.
  - sat_flags[k] <= sat[k] OR overflow from that add.
  - cnt[k] <= 0 and sat[k] <= 0.
  - rate_valid <= 1.
- rate_valid is 0 on every other cycle.
- clr has priority over en. With clr=1: wpos, cnt and sat are cleared. rate_out, sat_flags and rate_valid are not touched, so no pulse is issued.
- en=0: no state change except rate_valid <= 0. The window stretches to cover the disabled period.
- Reset values: wpos=0, cnt=0, sat=0, rate_out=0, sat_flags=0, rate_valid=0.
- Reset asserted mid-window discards the partial window. The first window after release is a full 2^WIN_LOG2 enabled cycles.

## Timing
- Registered outputs: rate_out, sat_flags, rate_valid. rate_sel is a combinational mux of rate_out.
- Latency: a spike in the last window cycle appears in rate_out one edge later, in the same cycle rate_valid=1.
- With en held high, publishes are exactly 2^WIN_LOG2 cycles apart. The first publish after reset release is at the edge ending enabled cycle 2^WIN_LOG2.
- clr and the last window cycle in the same cycle: clr wins, and there is no publish.
- rate_out holds its value between publishes and across en=0.

## Structure
- Shared package spike_rate_pkg holds:
  - defaults for N_CH, CNT_W, WIN_LOG2;
  - the channel-index constants CH_PRE1..CH_PRE4 and CH_POST, shared with the top level;
  - the function sat_inc (saturating increment with overflow flag).
- One sub-module, spike_rate_counter, per channel. It holds cnt[k] and sat[k], and takes inputs inc, last, clr and en. Its outputs are the next published count and the overflow flag.
- Top level owns wpos, rate_out, sat_flags, rate_valid and the sel mux.

## Test plan
- Reset, en=1, no spikes for 256 cycles: rate_valid pulses once at cycle 256; rate_out=0 and sat_flags=0.
- Channel 0 spikes every cycle, channel 4 spikes every 4th cycle, WIN_LOG2=8, CNT_W=8:
  - ch0 publishes 255 with sat_flags[0]=1;
  - ch4 publishes 64 with sat_flags[4]=0;
  - sel=4 gives rate_sel=64.
- Single spike on channel 2, only in the last window cycle: published rate for ch2 is 1, and the next window starts from 0.
- en low for 100 cycles mid-window while spikes toggle: those spikes are not counted, and the publish is delayed by exactly 100 cycles.
- clr pulse at wpos=200 with cnt[1]=50: there is no rate_valid, the previous rate_out is held, and the next publish comes 256 enabled cycles after clr.
- rst asserted mid-window with nonzero counts: all outputs are immediately 0, and after release the first publish comes after a full window.
